// File: rtl/matriz_pkg.sv
// Shared constants, state encoding and row-decode helper for the LED matrix row scanner.
// The APAGA state exists only when VARREDURA_MATRIZ_BLANKING_EN is defined.
package matriz_pkg;

  localparam int NUM_LINHAS  = 7;
  localparam int NUM_COLUNAS = 5;
  localparam int CONTADOR_W  = 3;

  localparam logic [CONTADOR_W-1:0] ULTIMA_LINHA = CONTADOR_W'(NUM_LINHAS - 1);

`ifdef VARREDURA_MATRIZ_BLANKING_EN
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXIBE  = 2'd1,
    APAGA  = 2'd2
  } estado_t;
`else
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXIBE  = 2'd1
  } estado_t;
`endif

  // Row index to active-high one-hot row enable.
  function automatic logic [NUM_LINHAS-1:0] linha_onehot(input logic [CONTADOR_W-1:0] idx);
    logic [NUM_LINHAS-1:0] base;
    base = {{(NUM_LINHAS-1){1'b0}}, 1'b1};
    return base << idx;
  endfunction

  function automatic logic [CONTADOR_W-1:0] proxima_linha(input logic [CONTADOR_W-1:0] idx);
    return (idx == ULTIMA_LINHA) ? '0 : idx + CONTADOR_W'(1);
  endfunction

endpackage

// File: rtl/varredura_matriz_divisor_tick.sv
// Row-period prescaler: counts 0..DIV-1 and emits a one-cycle tick on the last count.
// clear holds the count at zero so each row starts from a fresh period.
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [7:0] contagem;

  assign tick = !clear && (contagem == 8'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || clear || tick) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + 8'd1;
    end
  end

endmodule

// File: rtl/varredura_matriz.sv
// Row-multiplexed scanner for a 7x5 LED matrix; one row lit at a time for DIV cycles.
// Optional one-cycle blanking between rows: define VARREDURA_MATRIZ_BLANKING_EN.
module varredura_matriz
  import matriz_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             quadro_sel,
  input  logic [NUM_COLUNAS-1:0] colunas_in,
  output logic [CONTADOR_W-1:0]  contador,
  output logic [1:0]             quadro_ativo,
  output logic [NUM_LINHAS-1:0]  linhas,
  output logic [NUM_COLUNAS-1:0] colunas_out,
  output logic                   fim_quadro
);

  estado_t estado;
  logic    tick;
  logic    limpa_prescaler;

  assign limpa_prescaler = (estado != EXIBE);

  divisor_tick #(
    .DIV(DIV)
  ) u_divisor (
    .clock(clock),
    .reset(reset),
    .clear(limpa_prescaler),
    .tick (tick)
  );

  // contador always names the next row to load, so contador==0 while EXIBE means row 6 is lit.
  // The frame select is latched only when row 6 is loaded, keeping each frame self-consistent.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= OCIOSO;
      contador     <= '0;
      linhas       <= '0;
      colunas_out  <= '0;
      fim_quadro   <= 1'b0;
      quadro_ativo <= '0;
    end else if (!enable) begin
      if (estado == OCIOSO) begin
        quadro_ativo <= quadro_sel;
      end
      estado      <= OCIOSO;
      contador    <= '0;
      linhas      <= '0;
      colunas_out <= '0;
      fim_quadro  <= 1'b0;
    end else begin
      fim_quadro <= 1'b0;
      case (estado)
        OCIOSO: begin
          estado      <= EXIBE;
          linhas      <= linha_onehot('0);
          colunas_out <= colunas_in;
          contador    <= CONTADOR_W'(1);
        end
        EXIBE: begin
          if (tick) begin
            fim_quadro <= (contador == '0);
`ifdef VARREDURA_MATRIZ_BLANKING_EN
            estado      <= APAGA;
            linhas      <= '0;
            colunas_out <= '0;
`else
            linhas      <= linha_onehot(contador);
            colunas_out <= colunas_in;
            contador    <= proxima_linha(contador);
            if (contador == ULTIMA_LINHA) begin
              quadro_ativo <= quadro_sel;
            end
`endif
          end
        end
`ifdef VARREDURA_MATRIZ_BLANKING_EN
        APAGA: begin
          estado      <= EXIBE;
          linhas      <= linha_onehot(contador);
          colunas_out <= colunas_in;
          contador    <= proxima_linha(contador);
          if (contador == ULTIMA_LINHA) begin
            quadro_ativo <= quadro_sel;
          end
        end
`endif
        default: begin
          estado      <= OCIOSO;
          contador    <= '0;
          linhas      <= '0;
          colunas_out <= '0;
        end
      endcase
    end
  end

endmodule
